// File: rtl/mcp.sv
// Registered magnitude comparator with cascade inputs.
// Each accepted request produces a one-hot {G,E,L} result one cycle later.
// On an a==b tie the result comes from the less-significant stage's
// cascade inputs. There is no backpressure, and no input reaches an
// output without passing through a register.
module mcp #(
    parameter int WIDTH  = 1,
    parameter bit SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             gt_in,
    input  logic             eq_in,
    input  logic             lt_in,
    output logic             G,
    output logic             E,
    output logic             L,
    output logic             out_valid
);
    localparam int STAGES = 1;

    typedef struct packed {
        logic g;
        logic e;
        logic l;
    } res_t;

    // Inverting the sign bit maps two's-complement order onto unsigned
    // order. A single unsigned compare then covers both modes. This also
    // holds for WIDTH=1, where the value 1 stands for -1.
    localparam logic [WIDTH-1:0] MSB_FLIP = SIGNED ? (WIDTH'(1) << (WIDTH-1)) : '0;

    logic [WIDTH-1:0] a_k, b_k;
    res_t             cmp;
    res_t             res_q;
    logic [STAGES:1]  vld_pipe;

    // Combinational compare. On a tie the priority is eq_in > gt_in > lt_in,
    // and E is the default.
    always_comb begin
        a_k = a ^ MSB_FLIP;
        b_k = b ^ MSB_FLIP;
        cmp = '{g: 1'b0, e: 1'b0, l: 1'b0};
        if (a_k > b_k)     cmp.g = 1'b1;
        else if (a_k < b_k) cmp.l = 1'b1;
        else if (eq_in)     cmp.e = 1'b1;
        else if (gt_in)     cmp.g = 1'b1;
        else if (lt_in)     cmp.l = 1'b1;
        else                cmp.e = 1'b1;
    end

    // Result register. It holds its value while idle. Reset clears both
    // the result and the valid bit, and overrides a request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q    <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            if (in_valid) res_q <= cmp;
        end
    end

    assign G         = res_q.g;
    assign E         = res_q.e;
    assign L         = res_q.l;
    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_mcp.sv
// Scoreboard bench for mcp. Seven instances cover several WIDTH/SIGNED
// combinations, and all of them see the same stimulus. The stimulus process
// pushes per-instance expected {G,E,L} triples from an arithmetic model. The
// monitor pops and compares one triple each time out_valid is high. It also
// checks that idle cycles hold the last result and that reset clears the outputs.
module tb_mcp;
    localparam int N = 7;
    localparam int WS [N] = '{1, 1, 4, 8, 8, 32, 32};
    localparam bit SS [N] = '{0, 1, 0, 0, 1, 0, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic gt_in = 1'b0, eq_in = 1'b1, lt_in = 1'b0;
    logic [63:0] a_v = '0, b_v = '0;
    logic [N-1:0] G, E, L, ov;
    logic rst_d;

    logic [3*N-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_d <= rst;

    for (genvar i = 0; i < N; i++) begin : g_dut
        mcp #(.WIDTH(WS[i]), .SIGNED(SS[i])) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid),
            .a(a_v[WS[i]-1:0]), .b(b_v[WS[i]-1:0]),
            .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in),
            .G(G[i]), .E(E[i]), .L(L[i]), .out_valid(ov[i])
        );
    end

    // Reference model: integer compare after masking and sign extension.
    function automatic logic [2:0] model(int w, bit s, logic [63:0] aa, logic [63:0] bb,
                                         logic g, logic e, logic l);
        longint av, bv;
        longint mask;
        mask = (longint'(1) << w) - 1;
        av = longint'(aa) & mask;
        bv = longint'(bb) & mask;
        if (s && av[w-1]) av = av - (longint'(1) << w);
        if (s && bv[w-1]) bv = bv - (longint'(1) << w);
        if (av > bv) return 3'b100;
        if (av < bv) return 3'b001;
        if (e) return 3'b010;
        if (g) return 3'b100;
        if (l) return 3'b001;
        return 3'b010;
    endfunction

    // One clock of stimulus. The expected result is queued only when the
    // request is accepted.
    task automatic cyc(input bit v, input bit r, input logic [63:0] aa, input logic [63:0] bb,
                       input bit g, input bit e, input bit l);
        logic [3*N-1:0] ex;
        in_valid = v; rst = r; a_v = aa; b_v = bb;
        gt_in = g; eq_in = e; lt_in = l;
        @(posedge clk);
        if (v && !r) begin
            for (int i = 0; i < N; i++) ex[3*i +: 3] = model(WS[i], SS[i], aa, bb, g, e, l);
            exp_q.push_back(ex);
        end
        #1;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic [3*N-1:0] got, last, ex;
        last = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) got[3*i +: 3] = {G[i], E[i], L[i]};
            if (rst_d) begin
                checks++;
                if (ov !== '0 || got !== '0) begin
                    errors++;
                    $display("FAIL reset_clear: gel=%h ov=%b, expected all zero", got, ov);
                end
                last = '0;
            end else if (ov !== '0) begin
                checks++;
                if (ov !== '1) begin
                    errors++;
                    $display("FAIL valid_align: ov=%b, expected all ones", ov);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_valid: ov=%b with no pending request", ov);
                end else begin
                    ex = exp_q.pop_front();
                    if (got !== ex) begin
                        errors++;
                        $display("FAIL result: gel=%h expected %h (a=%h b=%h)", got, ex, a_v, b_v);
                    end
                    last = ex;
                end
                checks++;
                for (int i = 0; i < N; i++)
                    if (!$onehot({G[i], E[i], L[i]})) begin
                        errors++;
                        $display("FAIL onehot: inst %0d gel=%b", i, {G[i], E[i], L[i]});
                        break;
                    end
            end else begin
                checks++;
                if (got !== last) begin
                    errors++;
                    $display("FAIL hold: gel=%h expected %h", got, last);
                end
            end
        end
    end

    initial begin
        int n;
        logic [63:0] ra, rb;
        logic [2:0] c;
        // Reset for two cycles.
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        // A request that arrives together with reset is discarded.
        cyc(1, 1, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        // Truth table, back to back. Width 1 unsigned gives E, L, G, E.
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 1, 0);
        cyc(1, 0, 1, 0, 0, 1, 0);
        cyc(1, 0, 1, 1, 0, 1, 0);
        cyc(1, 0, 1, 0, 0, 1, 0);
        // Hold the G result over three idle cycles.
        cyc(0, 0, 7, 3, 1, 0, 0);
        cyc(0, 0, 2, 9, 0, 0, 1);
        cyc(0, 0, 5, 5, 0, 1, 0);
        // 0x80 vs 0x7F: unsigned gives G, signed 8-bit gives L.
        cyc(1, 0, 64'h80, 64'h7F, 0, 1, 0);
        // Tie with a=b=5: cascade gt only, lt only, then all zero.
        cyc(1, 0, 5, 5, 1, 0, 0);
        cyc(1, 0, 5, 5, 0, 0, 1);
        cyc(1, 0, 5, 5, 0, 0, 0);
        cyc(1, 0, 5, 5, 1, 1, 1);
        // Reset one cycle after a request, then the first request after release.
        cyc(1, 0, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        // Random operands. Sparse idle cycles and forced ties are mixed in.
        n = 0;
        while (n < 1000) begin
            ra = {$urandom(), $urandom()};
            rb = ($urandom_range(3) == 0) ? ra : {$urandom(), $urandom()};
            c  = 3'($urandom_range(7));
            if ($urandom_range(4) != 0) begin
                cyc(1, 0, ra, rb, c[2], c[1], c[0]);
                n++;
            end else begin
                cyc(0, 0, ra, rb, c[2], c[1], c[0]);
            end
        end
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drained: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
